// File: rtl/core_wb_sched_pkg.sv
// Shared types and constants for the write-back scheduler and its per-source FIFOs.
package core_wb_sched_pkg;

    typedef logic [3:0]  reg_num;
    typedef logic [31:0] word;

    typedef struct packed {
        reg_num rd;
        word    value;
    } wb_req;

    localparam int WB_N_SRC  = 4;
    localparam int WB_N_PORT = 3;
    localparam int WB_N_REG  = 16;

    localparam int WB_SRC_ALU_A = 0;
    localparam int WB_SRC_ALU_B = 1;
    localparam int WB_SRC_MULT  = 2;
    localparam int WB_SRC_LDST  = 3;

    function automatic logic [WB_N_REG-1:0] rd_onehot(input reg_num rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/core_wb_fifo.sv
// Small per-source holding FIFO of write-back requests; exposes its head and
// a one-hot mask of every buffered destination register.
module core_wb_fifo
    import core_wb_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                push,
    input  wb_req               push_data,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output wb_req               head,
    output logic [WB_N_REG-1:0] rd_mask
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req            mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        next_ptr = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            // push and pop never address the same slot: that needs an empty or a full FIFO
            if (push_ok) begin
                wr_ptr_reg            <= next_ptr(wr_ptr_reg);
                valid_reg[wr_ptr_reg] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg            <= next_ptr(rd_ptr_reg);
                valid_reg[rd_ptr_reg] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        rd_mask = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (valid_reg[j]) begin
                rd_mask = rd_mask | rd_onehot(mem[j].rd);
            end
        end
    end

endmodule

// File: rtl/core_wb_sched.sv
// Write-back scheduler: buffers producer results per source and grants up to three
// register-file write ports per cycle in round-robin order, avoiding same-rd collisions.
module core_wb_sched
    import core_wb_sched_pkg::*;
#(
    parameter int N_SRC  = WB_N_SRC,
    parameter int N_PORT = WB_N_PORT,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [N_SRC-1:0]    src_valid,
    input  logic [N_SRC*4-1:0]  src_rd,
    input  logic [N_SRC*32-1:0] src_value,
    output logic [N_SRC-1:0]    src_ready,
    output logic                wr_enable_a,
    output logic [3:0]          wr_r_a,
    output logic [31:0]         wr_value_a,
    output logic                wr_enable_b,
    output logic [3:0]          wr_r_b,
    output logic [31:0]         wr_value_b,
    output logic                wr_enable_c,
    output logic [3:0]          wr_r_c,
    output logic [31:0]         wr_value_c,
    output logic [15:0]         pend_mask,
    output logic                busy
);

    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int PW = $clog2(N_PORT + 1);

    wb_req               head [N_SRC];
    logic [WB_N_REG-1:0] fifo_mask [N_SRC];
    logic [N_SRC-1:0]    full;
    logic [N_SRC-1:0]    empty;
    logic [N_SRC-1:0]    grant;

    logic [SW-1:0]       rr_reg;
    logic [SW-1:0]       rr_next;
    logic [SW-1:0]       idx;
    logic [PW-1:0]       n_grant;
    logic [WB_N_REG-1:0] rd_taken;
    logic [N_PORT-1:0]   port_valid;
    wb_req               port_req [N_PORT];

    logic [N_PORT-1:0]   wr_en_reg;
    reg_num              wr_r_reg [N_PORT];
    word                 wr_value_reg [N_PORT];

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            wb_req push_data;
            assign push_data.rd    = src_rd[gi*4 +: 4];
            assign push_data.value = src_value[gi*32 +: 32];
            assign src_ready[gi]   = !full[gi];

            core_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .push      (src_valid[gi]),
                .push_data (push_data),
                .pop       (grant[gi]),
                .full      (full[gi]),
                .empty     (empty[gi]),
                .head      (head[gi]),
                .rd_mask   (fifo_mask[gi])
            );
        end
    endgenerate

    // Walk heads from rr; a head colliding with an rd already granted this cycle waits.
    always_comb begin
        grant      = '0;
        port_valid = '0;
        rd_taken   = '0;
        n_grant    = '0;
        idx        = '0;
        rr_next    = rr_reg;
        for (int p = 0; p < N_PORT; p++) begin
            port_req[p] = '0;
        end
        for (int k = 0; k < N_SRC; k++) begin
            idx = SW'((int'(rr_reg) + k) % N_SRC);
            if (!empty[idx] && (n_grant < PW'(N_PORT)) && !rd_taken[head[idx].rd]) begin
                grant[idx]                 = 1'b1;
                rd_taken[head[idx].rd]     = 1'b1;
                port_valid[n_grant[PW-1:0]] = 1'b1;
                port_req[n_grant[PW-1:0]]   = head[idx];
                n_grant                    = n_grant + 1'b1;
                rr_next                    = (idx == SW'(N_SRC - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg    <= '0;
            wr_en_reg <= '0;
            for (int p = 0; p < N_PORT; p++) begin
                wr_r_reg[p]     <= '0;
                wr_value_reg[p] <= '0;
            end
        end else if (flush) begin
            wr_en_reg <= '0;
        end else begin
            rr_reg    <= rr_next;
            wr_en_reg <= port_valid;
            for (int p = 0; p < N_PORT; p++) begin
                if (port_valid[p]) begin
                    wr_r_reg[p]     <= port_req[p].rd;
                    wr_value_reg[p] <= port_req[p].value;
                end
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pend_mask = pend_mask | fifo_mask[i];
        end
        for (int p = 0; p < N_PORT; p++) begin
            if (wr_en_reg[p]) begin
                pend_mask = pend_mask | rd_onehot(wr_r_reg[p]);
            end
        end
    end

    assign busy = (~&empty) | (|wr_en_reg);

    assign wr_enable_a = wr_en_reg[0];
    assign wr_r_a      = wr_r_reg[0];
    assign wr_value_a  = wr_value_reg[0];
    assign wr_enable_b = wr_en_reg[1];
    assign wr_r_b      = wr_r_reg[1];
    assign wr_value_b  = wr_value_reg[1];
    assign wr_enable_c = wr_en_reg[2];
    assign wr_r_c      = wr_r_reg[2];
    assign wr_value_c  = wr_value_reg[2];

endmodule

// File: tb/tb_core_wb_sched.sv
// Directed self-checking bench for core_wb_sched with hand-computed expectations.
module tb_core_wb_sched;
    import core_wb_sched_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush = 1'b0;
    logic [3:0]   src_valid = '0;
    logic [15:0]  src_rd = '0;
    logic [127:0] src_value = '0;
    logic [3:0]   src_ready;
    logic         wr_enable_a, wr_enable_b, wr_enable_c;
    logic [3:0]   wr_r_a, wr_r_b, wr_r_c;
    logic [31:0]  wr_value_a, wr_value_b, wr_value_c;
    logic [15:0]  pend_mask;
    logic         busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_wb_sched #(.N_SRC(4), .N_PORT(3), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_rd      (src_rd),
        .src_value   (src_value),
        .src_ready   (src_ready),
        .wr_enable_a (wr_enable_a),
        .wr_r_a      (wr_r_a),
        .wr_value_a  (wr_value_a),
        .wr_enable_b (wr_enable_b),
        .wr_r_b      (wr_r_b),
        .wr_value_b  (wr_value_b),
        .wr_enable_c (wr_enable_c),
        .wr_r_c      (wr_r_c),
        .wr_value_c  (wr_value_c),
        .pend_mask   (pend_mask),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int s, input logic [3:0] rd, input logic [31:0] v);
        src_valid[s]       = 1'b1;
        src_rd[s*4 +: 4]   = rd;
        src_value[s*32 +: 32] = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        src_valid = '0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_q [4][$];
    int          seq [4];
    int          wait_cnt [4];
    logic [3:0]  ready_dropped;
    logic        en_v [3];
    logic [3:0]  r_v [3];
    logic [31:0] val_v [3];
    logic [3:0]  served;
    logic [1:0]  s_id;
    logic [31:0] expv;

    initial begin
        // 1: reset with every producer asserting valid
        src_valid = 4'hF;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_en", 32'({wr_enable_a, wr_enable_b, wr_enable_c}), 32'd0);
        chk("rst_pend", 32'(pend_mask), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_r_a", 32'(wr_r_a), 32'd0);
        src_valid = '0;
        rst_n = 1'b1;
        #1 chk("rst_ready", 32'(src_ready), 32'hF);
        @(negedge clk);

        // 2: single result, minimum latency
        set_src(WB_SRC_ALU_A, 4'd3, 32'hDEADBEEF);
        cyc();
        src_valid = '0;
        chk("single_e0_en", 32'(wr_enable_a), 32'd0);
        chk("single_e0_pend", 32'(pend_mask), 32'h0008);
        cyc();
        chk("single_en_a", 32'(wr_enable_a), 32'd1);
        chk("single_r_a", 32'(wr_r_a), 32'd3);
        chk("single_val_a", wr_value_a, 32'hDEADBEEF);
        chk("single_bc_idle", 32'({wr_enable_b, wr_enable_c}), 32'd0);
        chk("single_pend", 32'(pend_mask), 32'h0008);
        chk("single_busy", 32'(busy), 32'd1);
        cyc();
        chk("single_done_en", 32'(wr_enable_a), 32'd0);
        chk("single_done_pend", 32'(pend_mask), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);

        // 3: all four sources at once from rr=0
        do_reset();
        set_src(0, 4'd1, 32'h0000_0A01);
        set_src(1, 4'd2, 32'h0000_0A02);
        set_src(2, 4'd4, 32'h0000_0A04);
        set_src(3, 4'd5, 32'h0000_0A05);
        cyc();
        src_valid = '0;
        chk("full_buf_pend", 32'(pend_mask), 32'h0036);
        cyc();
        chk("full_en", 32'({wr_enable_a, wr_enable_b, wr_enable_c}), 32'h7);
        chk("full_r_a", 32'(wr_r_a), 32'd1);
        chk("full_r_b", 32'(wr_r_b), 32'd2);
        chk("full_r_c", 32'(wr_r_c), 32'd4);
        chk("full_val_c", wr_value_c, 32'h0000_0A04);
        chk("full_pend", 32'(pend_mask), 32'h0036);
        cyc();
        chk("full2_en", 32'({wr_enable_a, wr_enable_b, wr_enable_c}), 32'h4);
        chk("full2_r_a", 32'(wr_r_a), 32'd5);
        chk("full2_val_a", wr_value_a, 32'h0000_0A05);
        chk("full2_hold_r_b", 32'(wr_r_b), 32'd2);
        chk("full2_pend", 32'(pend_mask), 32'h0020);
        cyc();
        chk("full3_busy", 32'(busy), 32'd0);

        // 4: same rd from two sources; rr must be back at 0
        set_src(1, 4'd7, 32'd1);
        set_src(2, 4'd7, 32'd2);
        cyc();
        src_valid = '0;
        chk("conf_pend", 32'(pend_mask), 32'h0080);
        cyc();
        chk("conf1_en", 32'({wr_enable_a, wr_enable_b, wr_enable_c}), 32'h4);
        chk("conf1_r_a", 32'(wr_r_a), 32'd7);
        chk("conf1_val_a", wr_value_a, 32'd1);
        cyc();
        chk("conf2_en", 32'({wr_enable_a, wr_enable_b, wr_enable_c}), 32'h4);
        chk("conf2_val_a", wr_value_a, 32'd2);
        cyc();
        chk("conf3_busy", 32'(busy), 32'd0);

        // 5: saturation with scoreboard, 40 push cycles then drain
        do_reset();
        ready_dropped = '0;
        for (int s = 0; s < 4; s++) begin
            seq[s] = 0;
            wait_cnt[s] = 0;
        end
        for (int c = 0; c < 52; c++) begin
            en_v[0] = wr_enable_a; r_v[0] = wr_r_a; val_v[0] = wr_value_a;
            en_v[1] = wr_enable_b; r_v[1] = wr_r_b; val_v[1] = wr_value_b;
            en_v[2] = wr_enable_c; r_v[2] = wr_r_c; val_v[2] = wr_value_c;
            served = '0;
            for (int p = 0; p < 3; p++) begin
                if (en_v[p]) begin
                    s_id = r_v[p][3:2];
                    served[s_id] = 1'b1;
                    expv = (exp_q[s_id].size() > 0) ? exp_q[s_id].pop_front() : 32'hFFFF_FFFF;
                    chk("sat_value", val_v[p], expv);
                    chk("sat_rd", 32'(r_v[p]), 32'({expv[25:24], expv[1:0]}));
                end
            end
            for (int s = 0; s < 4; s++) begin
                if (served[s]) wait_cnt[s] = 0;
                else if (exp_q[s].size() > 0) wait_cnt[s]++;
                chk("sat_starve", 32'(wait_cnt[s] <= 4), 32'd1);
            end
            ready_dropped = ready_dropped | ~src_ready;
            if (c < 40) begin
                for (int s = 0; s < 4; s++) begin
                    src_valid[s] = 1'b1;
                    if (src_ready[s]) begin
                        expv = {8'(s), 24'(seq[s])};
                        set_src(s, {2'(s), 2'(seq[s])}, expv);
                        exp_q[s].push_back(expv);
                        seq[s]++;
                    end
                end
            end else begin
                src_valid = '0;
            end
            cyc();
        end
        for (int s = 0; s < 4; s++) begin
            chk("sat_lost", 32'(exp_q[s].size()), 32'd0);
        end
        chk("sat_ready_drop", 32'(ready_dropped), 32'hF);
        chk("sat_idle", 32'(busy), 32'd0);

        // 6: flush with three buffered entries and a coincident push
        do_reset();
        set_src(0, 4'd1, 32'h11);
        set_src(1, 4'd2, 32'h22);
        set_src(2, 4'd4, 32'h44);
        cyc();
        src_valid = '0;
        chk("flush_pre_pend", 32'(pend_mask), 32'h0016);
        flush = 1'b1;
        set_src(WB_SRC_LDST, 4'd9, 32'h0BAD);
        cyc();
        flush = 1'b0;
        src_valid = '0;
        chk("flush_en", 32'({wr_enable_a, wr_enable_b, wr_enable_c}), 32'd0);
        chk("flush_pend", 32'(pend_mask), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_ready", 32'(src_ready), 32'hF);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("flush_after_en", 32'({wr_enable_a, wr_enable_b, wr_enable_c}), 32'd0);
            chk("flush_after_pend", 32'(pend_mask), 32'd0);
        end

        // 7: asynchronous reset while a port is being driven
        set_src(0, 4'd6, 32'h66);
        cyc();
        src_valid = '0;
        cyc();
        chk("arst_pre_en", 32'(wr_enable_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(wr_enable_a), 32'd0);
        chk("arst_val", wr_value_a, 32'd0);
        chk("arst_pend", 32'(pend_mask), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
